// File: rtl/tcas_scan_ctrl_if.sv
// Result handshake bundle of the TCAS interrogation scan controller.
// The master side presents one step result; the slave side accepts it with res_ready.
interface tcas_scan_ctrl_if;
  logic        res_valid;
  logic        res_ready;
  logic        res_ant;
  logic [2:0]  res_dir;
  logic [15:0] res_main;
  logic [15:0] res_omega;
  logic [15:0] res_omni;
  logic [8:0]  res_bearing;
  logic [15:0] res_time;

  modport master (
    output res_valid, res_ant, res_dir, res_main, res_omega, res_omni,
           res_bearing, res_time,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_ant, res_dir, res_main, res_omega, res_omni,
           res_bearing, res_time,
    output res_ready
  );
endinterface

// File: rtl/tcas_scan_ctrl.sv
// TCAS interrogation scan controller: steps antenna/direction, settles, listens for
// the peak MAIN amplitude in a fixed window and reports each step over valid/ready.
module tcas_scan_ctrl #(
  parameter int unsigned SETTLE = 8,
  parameter int unsigned LISTEN = 1000,
  parameter int unsigned NDIR   = 4
) (
  input  logic                 clk_20,
  input  logic                 reset_b,
  input  logic                 start,
  input  logic                 abort,
  input  logic [15:0]          ampl_main,
  input  logic [15:0]          ampl_omega,
  input  logic [15:0]          ampl_omni,
  input  logic [8:0]           bearing,
  output logic                 ant_top_bot,
  output logic [2:0]           dir_intrg,
  output logic                 busy,
  output logic                 done,
  tcas_scan_ctrl_if.master     res
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_LISTEN, S_REPORT} state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
  localparam logic [15:0] LISTEN_LAST = 16'(LISTEN - 1);
  localparam logic [2:0]  DIR_LAST    = 3'(NDIR - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [15:0] pk_main, pk_omega, pk_omni, pk_time;
  logic [8:0]  pk_bearing;
  logic        xfer, last_step, enter_settle;

  assign xfer         = (state == S_REPORT) && res.res_ready;
  assign last_step    = ant_top_bot && (dir_intrg == DIR_LAST);
  assign enter_settle = ((state == S_IDLE) && start && !abort) ||
                        (xfer && !last_step && !abort);

  always_ff @(posedge clk_20 or negedge reset_b) begin
    if (!reset_b) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start && !abort) state_nxt = S_SETTLE;
      S_SETTLE: if (abort) state_nxt = S_IDLE;
                else if (cnt == SETTLE_LAST) state_nxt = S_LISTEN;
      S_LISTEN: if (abort) state_nxt = S_IDLE;
                else if (cnt == LISTEN_LAST) state_nxt = S_REPORT;
      S_REPORT: if (abort) state_nxt = S_IDLE;
                else if (res.res_ready) state_nxt = last_step ? S_IDLE : S_SETTLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy            = (state != S_IDLE);
    res.res_valid   = (state == S_REPORT);
    res.res_ant     = ant_top_bot;
    res.res_dir     = dir_intrg;
    res.res_main    = pk_main;
    res.res_omega   = pk_omega;
    res.res_omni    = pk_omni;
    res.res_bearing = pk_bearing;
    res.res_time    = pk_time;
  end

  // Abort wins over everything, including a transfer on the same cycle; the
  // transferred result is simply not followed by another step or by done.
  always_ff @(posedge clk_20 or negedge reset_b) begin
    if (!reset_b) begin
      cnt         <= '0;
      ant_top_bot <= 1'b0;
      dir_intrg   <= '0;
      done        <= 1'b0;
      pk_main     <= '0;
      pk_omega    <= '0;
      pk_omni     <= '0;
      pk_bearing  <= '0;
      pk_time     <= '0;
    end else begin
      done <= xfer && last_step && !abort;
      if ((state != S_IDLE) && abort) begin
        cnt         <= '0;
        ant_top_bot <= 1'b0;
        dir_intrg   <= '0;
      end else if (enter_settle) begin
        cnt        <= '0;
        pk_main    <= '0;
        pk_omega   <= '0;
        pk_omni    <= '0;
        pk_bearing <= '0;
        pk_time    <= '0;
        if (state == S_REPORT) begin
          if (dir_intrg == DIR_LAST) begin
            dir_intrg   <= '0;
            ant_top_bot <= 1'b1;
          end else begin
            dir_intrg <= dir_intrg + 3'd1;
          end
        end else begin
          ant_top_bot <= 1'b0;
          dir_intrg   <= '0;
        end
      end else begin
        case (state)
          S_SETTLE: cnt <= (cnt == SETTLE_LAST) ? '0 : cnt + 16'd1;
          S_LISTEN: begin
            cnt <= (cnt == LISTEN_LAST) ? '0 : cnt + 16'd1;
            if (ampl_main > pk_main) begin
              pk_main    <= ampl_main;
              pk_omega   <= ampl_omega;
              pk_omni    <= ampl_omni;
              pk_bearing <= bearing;
              pk_time    <= cnt;
            end
          end
          S_REPORT: if (xfer) begin
            ant_top_bot <= 1'b0;
            dir_intrg   <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tcas_scan_ctrl.sv
// Self-checking bench for tcas_scan_ctrl: expected step results are queued as each
// window is driven and compared when the controller reports them.
module tb_tcas_scan_ctrl;
  localparam int SETTLE = 4;
  localparam int LISTEN = 16;
  localparam int NDIR   = 2;
  localparam int NSTEP  = 2 * NDIR;
  localparam int STEP_CYC = SETTLE + LISTEN + 1;

  typedef struct {
    logic        ant;
    logic [2:0]  dir;
    logic [15:0] main;
    logic [15:0] omega;
    logic [15:0] omni;
    logic [8:0]  bearing;
    logic [15:0] tidx;
  } exp_t;

  logic        clk_20 = 1'b0;
  logic        reset_b = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] ampl_main = '0, ampl_omega = '0, ampl_omni = '0;
  logic [8:0]  bearing = '0;
  logic        ant_top_bot, busy, done;
  logic [2:0]  dir_intrg;

  tcas_scan_ctrl_if res();

  tcas_scan_ctrl #(.SETTLE(SETTLE), .LISTEN(LISTEN), .NDIR(NDIR)) dut (
    .clk_20      (clk_20),
    .reset_b     (reset_b),
    .start       (start),
    .abort       (abort),
    .ampl_main   (ampl_main),
    .ampl_omega  (ampl_omega),
    .ampl_omni   (ampl_omni),
    .bearing     (bearing),
    .ant_top_bot (ant_top_bot),
    .dir_intrg   (dir_intrg),
    .busy        (busy),
    .done        (done),
    .res         (res)
  );

  always #5 clk_20 = ~clk_20;

  int cyc = 0;
  always @(posedge clk_20) cyc <= cyc + 1;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   step_pat[NSTEP];
  int   valid_cyc[NSTEP];

  task automatic tick();
    @(posedge clk_20);
    #1;
  endtask

  task automatic junk_inputs();
    ampl_main = 16'hFFFF; ampl_omega = 16'hFFFF; ampl_omni = 16'hFFFF; bearing = 9'h1FF;
  endtask

  // Called just after the edge that enters SETTLE for step s.
  task automatic drive_step(input int s, input int pat, input int hold, input bit poke,
                            input bit xfer);
    logic [15:0] m[LISTEN], o[LISTEN], n[LISTEN];
    logic [8:0]  b[LISTEN];
    exp_t e, got;
    for (int k = 0; k < LISTEN; k++) begin
      case (pat)
        0: begin m[k] = 16'(k + 1); o[k] = 16'(3 * k + 7); n[k] = 16'(k ^ 'h55); b[k] = 9'(10 * k); end
        1: begin
          m[k] = (k == 3 || k == 9) ? 16'd100 : 16'(k);
          b[k] = (k == 3) ? 9'd45 : (k == 9) ? 9'd90 : 9'(k);
          o[k] = 16'(1000 + k); n[k] = 16'(2000 + k);
        end
        2: begin m[k] = '0; o[k] = '0; n[k] = '0; b[k] = '0; end
        default: begin
          m[k] = 16'($urandom_range(0, 300)); o[k] = 16'($urandom); n[k] = 16'($urandom);
          b[k] = 9'($urandom_range(0, 359));
        end
      endcase
    end
    e.ant = 1'(s / NDIR); e.dir = 3'(s % NDIR);
    e.main = '0; e.omega = '0; e.omni = '0; e.bearing = '0; e.tidx = '0;
    for (int k = 0; k < LISTEN; k++)
      if (m[k] > e.main) begin
        e.main = m[k]; e.omega = o[k]; e.omni = n[k]; e.bearing = b[k]; e.tidx = 16'(k);
      end
    sb.push_back(e);

    n_checks++;
    if ({ant_top_bot, dir_intrg, busy, res.res_valid} !== {e.ant, e.dir, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL step_entry s=%0d: got ant/dir/busy/valid %b want %b", s,
               {ant_top_bot, dir_intrg, busy, res.res_valid}, {e.ant, e.dir, 1'b1, 1'b0});
    end
    junk_inputs();
    repeat (SETTLE) tick();
    for (int k = 0; k < LISTEN; k++) begin
      ampl_main = m[k]; ampl_omega = o[k]; ampl_omni = n[k]; bearing = b[k];
      start = poke && (k == 5);
      tick();
      if (k == LISTEN - 2) begin
        n_checks++;
        if (res.res_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL early_valid s=%0d: got %b want 0", s, res.res_valid);
        end
      end
    end
    start = 1'b0;
    junk_inputs();

    n_checks++;
    if (res.res_valid !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL report_valid s=%0d: got valid=%b done=%b want valid=1 done=0", s,
               res.res_valid, done);
    end
    valid_cyc[s] = cyc;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_empty s=%0d: got 0 entries want 1", s);
      return;
    end
    got = sb.pop_front();
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin
        res.res_ready = 1'b0;
        tick();
      end
      n_checks++;
      if ({res.res_valid, res.res_ant, res.res_dir, res.res_main, res.res_omega, res.res_omni,
           res.res_bearing, res.res_time} !==
          {1'b1, got.ant, got.dir, got.main, got.omega, got.omni, got.bearing, got.tidx}) begin
        n_fail++;
        $display("FAIL result s=%0d h=%0d: got v=%b ant=%0d dir=%0d main=%0d omega=%0d omni=%0d brg=%0d t=%0d want v=1 ant=%0d dir=%0d main=%0d omega=%0d omni=%0d brg=%0d t=%0d",
                 s, h, res.res_valid, res.res_ant, res.res_dir, res.res_main, res.res_omega,
                 res.res_omni, res.res_bearing, res.res_time, got.ant, got.dir, got.main,
                 got.omega, got.omni, got.bearing, got.tidx);
      end
    end
    if (!xfer) begin
      res.res_ready = 1'b0;
      return;
    end
    res.res_ready = 1'b1;
    tick();
  endtask

  task automatic run_scan(input int hold0, input bit poke);
    int t0, total, gap;
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    for (int s = 0; s < NSTEP; s++)
      drive_step(s, step_pat[s], (s == 0) ? hold0 : 0, poke && (s == 1), 1'b1);
    total = cyc - t0;
    n_checks++;
    if ({done, busy, ant_top_bot, dir_intrg} !== 6'b100000) begin
      n_fail++;
      $display("FAIL scan_done: got done/busy/ant/dir %b want 100000",
               {done, busy, ant_top_bot, dir_intrg});
    end
    n_checks++;
    if (total != NSTEP * STEP_CYC + hold0) begin
      n_fail++;
      $display("FAIL scan_length: got %0d cycles want %0d", total, NSTEP * STEP_CYC + hold0);
    end
    for (int s = 1; s < NSTEP; s++) begin
      gap = valid_cyc[s] - valid_cyc[s - 1];
      n_checks++;
      if (gap != STEP_CYC + ((s == 1) ? hold0 : 0)) begin
        n_fail++;
        $display("FAIL result_spacing s=%0d: got %0d want %0d", s, gap,
                 STEP_CYC + ((s == 1) ? hold0 : 0));
      end
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse_width: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_reset();
    reset_b = 1'b0;
    res.res_ready = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({busy, done, ant_top_bot, dir_intrg, res.res_valid, res.res_ant, res.res_dir,
         res.res_main, res.res_omega, res.res_omni, res.res_bearing, res.res_time} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b valid=%b main=%0d want all 0",
               busy, done, res.res_valid, res.res_main);
    end
    reset_b = 1'b1;
    tick();
  endtask

  task automatic test_full_scan();
    for (int i = 0; i < 20 && cyc < 9; i++) tick();
    for (int s = 0; s < NSTEP; s++) step_pat[s] = 0;
    run_scan(0, 1'b1);
  endtask

  task automatic test_peak_tie_zero();
    step_pat[0] = 1; step_pat[1] = 2; step_pat[2] = 3; step_pat[3] = 3;
    run_scan(0, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int s = 0; s < NSTEP; s++) step_pat[s] = 3;
    run_scan(7, 1'b0);
  endtask

  task automatic test_abort();
    start = 1'b1;
    tick();
    start = 1'b0;
    drive_step(0, 3, 0, 1'b0, 1'b1);
    repeat (SETTLE) tick();
    for (int k = 0; k < 5; k++) begin
      ampl_main = 16'($urandom); ampl_omega = 16'($urandom);
      tick();
    end
    n_checks++;
    if ({busy, ant_top_bot, dir_intrg} !== 5'b10001) begin
      n_fail++;
      $display("FAIL pre_abort: got busy/ant/dir %b want 10001", {busy, ant_top_bot, dir_intrg});
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if ({busy, ant_top_bot, dir_intrg, res.res_valid, done} !== '0) begin
      n_fail++;
      $display("FAIL abort_idle: got busy/ant/dir/valid/done %b want 0",
               {busy, ant_top_bot, dir_intrg, res.res_valid, done});
    end
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
        tick();
        if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin
        n_fail++;
        $display("FAIL abort_quiet: got done/busy activity=1 want 0");
      end
    end
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_with_abort: got busy=%b want 0", busy);
    end
    for (int s = 0; s < NSTEP; s++) step_pat[s] = 0;
    run_scan(0, 1'b0);
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    drive_step(0, 3, 0, 1'b0, 1'b0);
    #3;
    reset_b = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, ant_top_bot, dir_intrg, res.res_valid, res.res_main, res.res_omega,
         res.res_omni, res.res_bearing, res.res_time} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b valid=%b main=%0d time=%0d want all 0",
               busy, res.res_valid, res.res_main, res.res_time);
    end
    @(posedge clk_20);
    #1;
    reset_b = 1'b1;
    res.res_ready = 1'b1;
    tick();
    for (int s = 0; s < NSTEP; s++) step_pat[s] = (s == 2) ? 1 : 3;
    run_scan(0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_peak_tie_zero();
    test_backpressure();
    test_abort();
    test_async_reset();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
